// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, baud-rate math and debug command bytes
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, HOLD} uart_state_e;
  localparam logic [7:0] CMD_R = 8'h72;
  localparam logic [7:0] CMD_S = 8'h73;
  localparam logic [7:0] CMD_L = 8'h6C;
  localparam logic [7:0] CMD_N = 8'h6E;
  function automatic int calc_tick_div(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction
endpackage

// File: rtl/uart_rx_oversampled_if.sv
// uart_rx_oversampled_if: serial line in, received byte and status out
interface uart_rx_oversampled_if #(parameter int DATA_BITS = 8);
  logic i_rx;
  logic [DATA_BITS-1:0] o_data;
  logic o_data_received;
  logic o_frame_err;
  logic o_busy;
  modport master (output i_rx, input o_data, o_data_received, o_frame_err, o_busy);
  modport slave (input i_rx, output o_data, o_data_received, o_frame_err, o_busy);
endinterface

// File: rtl/uart_baud_tick_gen.sv
// uart_baud_tick_gen: one-cycle tick every TICK_DIV clocks, restartable by i_clear
module uart_baud_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] cnt;
  // modulo-TICK_DIV counter; a clear puts the next tick TICK_DIV cycles away
  always_ff @(posedge i_clk)
    cnt <= (i_rst || i_clear || cnt == LAST) ? '0 : cnt + 1'b1;
  assign o_tick = cnt == LAST && !i_clear;
endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampling UART receiver holding each byte until reset
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 19200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input logic i_clk,
  input logic i_rst,
  uart_rx_oversampled_if.slave bus
);
  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  uart_state_e state, state_nx;
  logic sync1, rx_s, rx_prev, start_edge, tick, clear;
  logic mid_hit, data_hit, stop_hit;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg, data_q;
  logic rcvd_q, ferr_q;
  uart_baud_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clear(clear),
    .o_tick(tick)
  );
  // two-flop synchronizer plus one-cycle delayed copy for falling-edge detection
  always_ff @(posedge i_clk)
    {rx_prev, rx_s, sync1} <= i_rst ? 3'b111 : {rx_s, sync1, bus.i_rx};
  assign start_edge = rx_prev & ~rx_s;
  // state register
  always_ff @(posedge i_clk)
    state <= i_rst ? IDLE : state_nx;
  // next-state logic; HOLD is left only through reset
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start_edge ? START : IDLE;
      START: state_nx = mid_hit ? (rx_s ? IDLE : DATA) : START;
      DATA:  state_nx = (data_hit && bit_cnt == LAST_BIT) ? STOP : DATA;
      STOP:  state_nx = stop_hit ? (rx_s ? HOLD : IDLE) : STOP;
      default: state_nx = HOLD;
    endcase
  end
  // per-state strobes: divider restart and the three sample points
  always_comb begin
    clear = state == IDLE && start_edge;
    mid_hit = state == START && tick && tick_cnt == MID;
    data_hit = state == DATA && tick && tick_cnt == FULL;
    stop_hit = state == STOP && tick && tick_cnt == FULL;
  end
  // counters, shift register and held outputs
  always_ff @(posedge i_clk)
    if (i_rst) begin
      tick_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      data_q <= '0;
      rcvd_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      tick_cnt <= (state == IDLE || mid_hit || data_hit || stop_hit) ? '0 : tick_cnt + TW'(tick);
      bit_cnt <= state == START ? '0 : bit_cnt + BW'(data_hit);
      if (data_hit) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (stop_hit && rx_s) data_q <= shreg;
      if (stop_hit && rx_s) rcvd_q <= 1'b1;
      ferr_q <= stop_hit && !rx_s;
    end
  assign bus.o_data = data_q;
  assign bus.o_data_received = rcvd_q;
  assign bus.o_frame_err = ferr_q;
  assign bus.o_busy = state == START || state == DATA || state == STOP;
endmodule
